// File: rtl/async_operator_fifo.sv
// ---------------------------------------------------------------------------
// async_operator_fifo
//
// Purpose:
//   Collects one operand from each of INPUT_SIZE upstream channels via a
//   req/ack handshake, applies the OP operator, and pushes the result into a
//   DEPTH-entry FIFO. Each FIFO token is delivered exactly once, in order, to
//   each of OUTPUT_SIZE independent consumers. A token pops when the last
//   consumer that has not yet received it is acknowledged.
//
// Parameters:
//   DATA_WIDTH  operand/result width
//   OP          "reg" | "in" | "out" | "add" | "sub" | "mul" |
//               "addi" | "subi" | "muli"
//   IMMEDIATE   constant operand for addi/subi/muli (unsigned)
//   INPUT_SIZE  number of upstream operand channels (1..4)
//   OUTPUT_SIZE number of downstream consumers (1..8)
//   DEPTH       result FIFO entries (1..16)
//
// Ports:
//   clk          clock, all state on rising edge
//   rst          synchronous active-high reset
//   req_l  [IN]  operand request per upstream channel
//   ack_l  [IN]  one-cycle upstream acknowledge, din slice valid while high
//   din          packed operands, channel i at [DATA_WIDTH*i +: DATA_WIDTH]
//   req_r  [OUT] result request per consumer
//   ack_r  [OUT] one-cycle result acknowledge per consumer
//   dout         registered result, valid whenever any ack_r bit is high
//
// Optional feature (macro ASYNC_OPERATOR_STATS_EN):
//   fire_count   number of results pushed (wraps at 2^32)
//   stall_count  cycles with all operands held but the FIFO full
// ---------------------------------------------------------------------------
module async_operator_fifo #(
  parameter int          DATA_WIDTH  = 32,
  parameter string       OP          = "reg",
  parameter int unsigned IMMEDIATE   = 0,
  parameter int          INPUT_SIZE  = 1,
  parameter int          OUTPUT_SIZE = 1,
  parameter int          DEPTH       = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  output logic [INPUT_SIZE-1:0]            req_l,
  input  logic [INPUT_SIZE-1:0]            ack_l,
  input  logic [DATA_WIDTH*INPUT_SIZE-1:0] din,
  input  logic [OUTPUT_SIZE-1:0]           req_r,
  output logic [OUTPUT_SIZE-1:0]           ack_r,
  output logic [DATA_WIDTH-1:0]            dout
`ifdef ASYNC_OPERATOR_STATS_EN
  ,
  output logic [31:0]                      fire_count,
  output logic [31:0]                      stall_count
`endif
);

  // Operator selector: 0 pass d0, 1 add, 2 sub, 3 mul, 4 addi, 5 subi, 6 muli
  localparam int OP_SEL = (OP == "add")  ? 1 :
                          (OP == "sub")  ? 2 :
                          (OP == "mul")  ? 3 :
                          (OP == "addi") ? 4 :
                          (OP == "subi") ? 5 :
                          (OP == "muli") ? 6 : 0;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [DATA_WIDTH-1:0] IMM = DATA_WIDTH'(IMMEDIATE);

  logic [DATA_WIDTH-1:0]  din_slice [INPUT_SIZE];
  logic [DATA_WIDTH-1:0]  opnd_reg  [INPUT_SIZE];
  logic [INPUT_SIZE-1:0]  has_reg;
  logic [DATA_WIDTH-1:0]  mem       [DEPTH];
  logic [PW-1:0]          rd_ptr_reg;
  logic [PW-1:0]          wr_ptr_reg;
  logic [CW-1:0]          count_reg;
  logic [OUTPUT_SIZE-1:0] sent_reg;
  logic [OUTPUT_SIZE-1:0] raise;
  logic [DATA_WIDTH-1:0]  result;
  logic                   all_has;
  logic                   full;
  logic                   nonempty;
  logic                   any_raise;
  logic                   pop;
  logic                   fire;

  genvar gi;
  generate
    for (gi = 0; gi < INPUT_SIZE; gi++) begin : g_unpack
      assign din_slice[gi] = din[DATA_WIDTH*gi +: DATA_WIDTH];
    end
    // A consumer is served when it asks, has not yet seen the head token,
    // and is not in the cycle right after its previous acknowledge.
    for (gi = 0; gi < OUTPUT_SIZE; gi++) begin : g_raise
      assign raise[gi] = nonempty && req_r[gi] && !sent_reg[gi] && !ack_r[gi];
    end
  endgenerate

  assign all_has   = &has_reg;
  assign full      = (count_reg == CW'(DEPTH));
  assign nonempty  = (count_reg != '0);
  assign any_raise = |raise;
  // Head retires once every consumer has it, counting the ones served now.
  assign pop       = any_raise && (&(sent_reg | raise));
  // A same-edge pop frees the slot the new result will occupy.
  assign fire      = all_has && (!full || pop);

  // Left fold over channels starting at channel 0, then the immediate.
  always_comb begin
    result = opnd_reg[0];
    for (int i = 1; i < INPUT_SIZE; i++) begin
      case (OP_SEL)
        1, 4:    result = result + opnd_reg[i];
        2, 5:    result = result - opnd_reg[i];
        3, 6:    result = result * opnd_reg[i];
        default: result = result;
      endcase
    end
    case (OP_SEL)
      4:       result = result + IMM;
      5:       result = result - IMM;
      6:       result = result * IMM;
      default: result = result;
    endcase
  end

  // Operand storage needs no reset: has_reg alone qualifies it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < INPUT_SIZE; i++) begin
      if (!has_reg[i] && ack_l[i]) begin
        opnd_reg[i] <= din_slice[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_l   <= '0;
      has_reg <= '0;
    end else begin
      for (int i = 0; i < INPUT_SIZE; i++) begin
        if (!has_reg[i] && ack_l[i]) begin
          has_reg[i] <= 1'b1;
          req_l[i]   <= 1'b0;
        end else begin
          if (fire) begin
            has_reg[i] <= 1'b0;
          end
          // Request goes out one edge after the channel is free and idle.
          if (!has_reg[i] && !req_l[i]) begin
            req_l[i] <= 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fire) begin
      mem[wr_ptr_reg] <= result;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_r      <= '0;
      sent_reg   <= '0;
      dout       <= '0;
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      ack_r <= raise;
      if (any_raise) begin
        dout <= mem[rd_ptr_reg];
      end
      sent_reg <= pop ? '0 : (sent_reg | raise);
      if (fire) begin
        wr_ptr_reg <= (wr_ptr_reg == PW'(DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= (rd_ptr_reg == PW'(DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
      end
      count_reg <= count_reg + CW'(fire) - CW'(pop);
    end
  end

`ifdef ASYNC_OPERATOR_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fire_count  <= '0;
      stall_count <= '0;
    end else begin
      if (fire) begin
        fire_count <= fire_count + 32'd1;
      end
      if (all_has && !fire) begin
        stall_count <= stall_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_async_operator_fifo.sv
// ---------------------------------------------------------------------------
// tb_async_operator_fifo
//
// Three instances:
//   A: sub, 3 inputs, 2 consumers, depth 2 (random traffic, stall, reset)
//   B: subi #1, 1 input, 2 consumers, depth 1 (101-token ordered stream)
//   C: add, 2 inputs, 1 consumer, depth 2 (minimum latency)
// Inputs are driven and outputs sampled on the falling edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_async_operator_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // ---------------- DUT A ----------------
  logic        a_rst;
  logic [2:0]  a_req_l, a_ack_l;
  logic [95:0] a_din;
  logic [1:0]  a_req_r, a_ack_r;
  logic [31:0] a_dout;
`ifdef ASYNC_OPERATOR_STATS_EN
  logic [31:0] a_fire, a_stall;
`endif

  async_operator_fifo #(.DATA_WIDTH(32), .OP("sub"), .IMMEDIATE(0),
                        .INPUT_SIZE(3), .OUTPUT_SIZE(2), .DEPTH(2)) dut_a (
    .clk(clk), .rst(a_rst), .req_l(a_req_l), .ack_l(a_ack_l), .din(a_din),
    .req_r(a_req_r), .ack_r(a_ack_r), .dout(a_dout)
`ifdef ASYNC_OPERATOR_STATS_EN
    , .fire_count(a_fire), .stall_count(a_stall)
`endif
  );

  // Reference: per-channel operand history; token k = ch0[k] - ch1[k] - ch2[k].
  logic [31:0] opq_a [3][$];
  int          idx_a [2];
  logic [1:0]  prev_ack_a;
  bit          mon_a = 1'b0;

  function automatic int tokens_a();
    int m = opq_a[0].size();
    for (int i = 1; i < 3; i++) if (opq_a[i].size() < m) m = opq_a[i].size();
    return m;
  endfunction

  function automatic logic [31:0] model_a(input int k);
    return opq_a[0][k] - opq_a[1][k] - opq_a[2][k];
  endfunction

  always @(negedge clk) begin
    if (mon_a) begin
      for (int j = 0; j < 2; j++) begin
        if (a_ack_r[j]) begin
          check_val($sformatf("a_ack_once_c%0d", j), 64'(prev_ack_a[j]), 64'd0);
          if (idx_a[j] < tokens_a())
            check_val($sformatf("a_dout_c%0d_t%0d", j, idx_a[j]), 64'(a_dout), 64'(model_a(idx_a[j])));
          else
            check_val($sformatf("a_unexpected_ack_c%0d", j), 64'(idx_a[j]), 64'(tokens_a()));
          idx_a[j] <= idx_a[j] + 1;
        end
      end
    end
    prev_ack_a <= a_ack_r;
  end

  // One falling-edge step: acknowledge requesting channels (probability pct)
  // while their history is below the cap; capped channels keep requesting.
  task automatic a_cycle(input int cap01, input int cap2, input int pct);
    logic [31:0] v;
    int cap;
    @(negedge clk);
    a_ack_l = '0;
    for (int i = 0; i < 3; i++) begin
      cap = (i == 2) ? cap2 : cap01;
      if (a_req_l[i] && opq_a[i].size() < cap && $urandom_range(99) < pct) begin
        v = $urandom;
        a_ack_l[i] = 1'b1;
        a_din[32*i +: 32] = v;
        opq_a[i].push_back(v);
      end
    end
  endtask

  bit done_a = 1'b0;
  initial begin
    int s;
    logic [1:0] seen;
`ifdef ASYNC_OPERATOR_STATS_EN
    logic [31:0] s0;
`endif
    a_rst = 1'b1; a_ack_l = '0; a_din = '0; a_req_r = '0;
    idx_a[0] = 0; idx_a[1] = 0; prev_ack_a = '0;
    repeat (3) @(negedge clk);
    check_val("a_rst_req_l", 64'(a_req_l), 64'd0);
    check_val("a_rst_ack_r", 64'(a_ack_r), 64'd0);
    check_val("a_rst_dout", 64'(a_dout), 64'd0);
`ifdef ASYNC_OPERATOR_STATS_EN
    check_val("a_rst_fire_count", 64'(a_fire), 64'd0);
    check_val("a_rst_stall_count", 64'(a_stall), 64'd0);
`endif
    a_rst = 1'b0;
    @(negedge clk);
    check_val("a_req_l_after_rst", 64'(a_req_l), 64'h7);
    mon_a = 1'b1;

    // 10 - 3 - 2 = 5, acknowledged two edges after the push edge
    a_req_r = 2'b11;
    a_ack_l = 3'b111;
    a_din = {32'd2, 32'd3, 32'd10};
    opq_a[0].push_back(32'd10); opq_a[1].push_back(32'd3); opq_a[2].push_back(32'd2);
    @(negedge clk); a_ack_l = '0;
    @(negedge clk);
    @(negedge clk);
    check_val("a_sub_latency_ack", 64'(a_ack_r), 64'h3);
    check_val("a_sub_dout", 64'(a_dout), 64'd5);

    // Consumer 1 withholds: two tokens fill the FIFO, the third stays in has.
    a_req_r = 2'b01;
    repeat (30) a_cycle(4, 4, 100);
    a_cycle(4, 4, 0);
    check_val("a_stall_req_l_held", 64'(a_req_l), 64'd0);
    check_val("a_stall_c0_count", 64'(idx_a[0]), 64'd2);
    check_val("a_stall_c1_count", 64'(idx_a[1]), 64'd1);
`ifdef ASYNC_OPERATOR_STATS_EN
    check_val("a_stall_fire_count", 64'(a_fire), 64'd3);
    s0 = a_stall;
    repeat (5) a_cycle(4, 4, 0);
    check_val("a_stall_count_step", 64'(a_stall), 64'(s0 + 32'd5));
`endif
    a_req_r = 2'b11;
    for (int c = 0; c < 60 && !(idx_a[0] == 4 && idx_a[1] == 4); c++) a_cycle(4, 4, 0);
    check_val("a_release_c0_count", 64'(idx_a[0]), 64'd4);
    check_val("a_release_c1_count", 64'(idx_a[1]), 64'd4);

    // Random traffic on both sides
    for (int c = 0; c < 400; c++) begin
      a_cycle(100000, 100000, 50);
      a_req_r = 2'($urandom);
    end
    a_cycle(100000, 100000, 0);
    a_req_r = 2'b11;
    for (int c = 0; c < 100 && !(idx_a[0] == tokens_a() && idx_a[1] == tokens_a()); c++)
      a_cycle(0, 0, 0);
    check_val("a_drain_c0_count", 64'(idx_a[0]), 64'(tokens_a()));
    check_val("a_drain_c1_count", 64'(idx_a[1]), 64'(tokens_a()));

    // Fill FIFO, leave channels 0/1 holding a fresh operand, then reset.
    mon_a = 1'b0;
    a_req_r = 2'b00;
    s = tokens_a();
    repeat (30) a_cycle(s + 3, s + 2, 100);
    a_cycle(0, 0, 0);
    check_val("a_partial_req_l", 64'(a_req_l), 64'h4);
    a_rst = 1'b1;
    @(negedge clk);
    check_val("a_midrst_req_l", 64'(a_req_l), 64'd0);
    check_val("a_midrst_ack_r", 64'(a_ack_r), 64'd0);
    check_val("a_midrst_dout", 64'(a_dout), 64'd0);
`ifdef ASYNC_OPERATOR_STATS_EN
    check_val("a_midrst_fire_count", 64'(a_fire), 64'd0);
    check_val("a_midrst_stall_count", 64'(a_stall), 64'd0);
`endif
    a_rst = 1'b0;
    @(negedge clk);
    check_val("a_req_l_after_midrst", 64'(a_req_l), 64'h7);
    a_req_r = 2'b11;
    seen = '0;
    repeat (5) begin
      @(negedge clk);
      seen = seen | a_ack_r;
    end
    check_val("a_fifo_empty_after_rst", 64'(seen), 64'd0);
    a_ack_l = 3'b111;
    a_din = {32'd1, 32'd1, 32'd1};
    @(negedge clk); a_ack_l = '0;
    @(negedge clk);
    @(negedge clk);
    check_val("a_post_rst_ack", 64'(a_ack_r), 64'h3);
    check_val("a_post_rst_dout", 64'(a_dout), 64'hFFFF_FFFF);
    done_a = 1'b1;
  end

  // ---------------- DUT B ----------------
  logic        b_rst;
  logic [0:0]  b_req_l, b_ack_l;
  logic [31:0] b_din;
  logic [1:0]  b_req_r, b_ack_r;
  logic [31:0] b_dout;
`ifdef ASYNC_OPERATOR_STATS_EN
  logic [31:0] b_fire, b_stall;
`endif

  async_operator_fifo #(.DATA_WIDTH(32), .OP("subi"), .IMMEDIATE(1),
                        .INPUT_SIZE(1), .OUTPUT_SIZE(2), .DEPTH(1)) dut_b (
    .clk(clk), .rst(b_rst), .req_l(b_req_l), .ack_l(b_ack_l), .din(b_din),
    .req_r(b_req_r), .ack_r(b_ack_r), .dout(b_dout)
`ifdef ASYNC_OPERATOR_STATS_EN
    , .fire_count(b_fire), .stall_count(b_stall)
`endif
  );

  // Operands 0..100 are fed; expected results operand-1 mod 2^32,
  // i.e. 0xFFFFFFFF followed by 0..99.
  logic [31:0] exp_b [$];
  int          idx_b [2];
  logic [1:0]  prev_ack_b;
  bit          mon_b = 1'b0;

  always @(negedge clk) begin
    if (mon_b) begin
      for (int j = 0; j < 2; j++) begin
        if (b_ack_r[j]) begin
          check_val($sformatf("b_ack_once_c%0d", j), 64'(prev_ack_b[j]), 64'd0);
          if (idx_b[j] < exp_b.size())
            check_val($sformatf("b_dout_c%0d_t%0d", j, idx_b[j]), 64'(b_dout), 64'(exp_b[idx_b[j]]));
          else
            check_val($sformatf("b_unexpected_ack_c%0d", j), 64'(idx_b[j]), 64'(exp_b.size()));
          idx_b[j] <= idx_b[j] + 1;
        end
      end
    end
    prev_ack_b <= b_ack_r;
  end

  bit done_b = 1'b0;
  initial begin
    int fb;
    b_rst = 1'b1; b_ack_l = '0; b_din = '0; b_req_r = '0;
    idx_b[0] = 0; idx_b[1] = 0; prev_ack_b = '0;
    for (int k = 0; k <= 100; k++) exp_b.push_back(32'(k) - 32'd1);
    repeat (2) @(negedge clk);
    check_val("b_rst_req_l", 64'(b_req_l), 64'd0);
    check_val("b_rst_ack_r", 64'(b_ack_r), 64'd0);
    b_rst = 1'b0;
    b_req_r = 2'b11;
    mon_b = 1'b1;
    fb = 0;
    for (int c = 0; c < 1500 && !(idx_b[0] == 101 && idx_b[1] == 101); c++) begin
      @(negedge clk);
      b_ack_l = '0;
      if (b_req_l[0] && fb <= 100) begin
        b_ack_l[0] = 1'b1;
        b_din = 32'(fb);
        fb++;
      end
    end
    @(negedge clk);
    check_val("b_c0_token_count", 64'(idx_b[0]), 64'd101);
    check_val("b_c1_token_count", 64'(idx_b[1]), 64'd101);
    done_b = 1'b1;
  end

  // ---------------- DUT C ----------------
  logic        c_rst;
  logic [1:0]  c_req_l, c_ack_l;
  logic [63:0] c_din;
  logic [0:0]  c_req_r, c_ack_r;
  logic [31:0] c_dout;
`ifdef ASYNC_OPERATOR_STATS_EN
  logic [31:0] c_fire, c_stall;
`endif

  async_operator_fifo #(.DATA_WIDTH(32), .OP("add"), .IMMEDIATE(0),
                        .INPUT_SIZE(2), .OUTPUT_SIZE(1), .DEPTH(2)) dut_c (
    .clk(clk), .rst(c_rst), .req_l(c_req_l), .ack_l(c_ack_l), .din(c_din),
    .req_r(c_req_r), .ack_r(c_ack_r), .dout(c_dout)
`ifdef ASYNC_OPERATOR_STATS_EN
    , .fire_count(c_fire), .stall_count(c_stall)
`endif
  );

  bit done_c = 1'b0;
  initial begin
    c_rst = 1'b1; c_ack_l = '0; c_din = '0; c_req_r = '0;
    repeat (2) @(negedge clk);
    check_val("c_rst_dout", 64'(c_dout), 64'd0);
    c_rst = 1'b0;
    for (int c = 0; c < 5 && c_req_l != 2'b11; c++) @(negedge clk);
    check_val("c_req_l_up", 64'(c_req_l), 64'h3);
    c_req_r = 1'b1;
    c_ack_l = 2'b11;
    c_din = {32'd7, 32'd5};
    @(negedge clk); c_ack_l = '0;
    check_val("c_ack_r_e0", 64'(c_ack_r), 64'd0);
    @(negedge clk);
    check_val("c_ack_r_e1", 64'(c_ack_r), 64'd0);
    @(negedge clk);
    check_val("c_ack_r_e2", 64'(c_ack_r), 64'd1);
    check_val("c_add_dout", 64'(c_dout), 64'd12);
    @(negedge clk);
    check_val("c_ack_r_e3", 64'(c_ack_r), 64'd0);
    done_c = 1'b1;
  end

  // ---------------- summary ----------------
  initial begin
    wait (done_a && done_b && done_c);
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected all phases done (a=%0d b=%0d c=%0d)",
             done_a, done_b, done_c);
    $fatal(1, "watchdog");
  end

endmodule
